// File: rtl/student_iic_target_pkg.sv
// Shared types and constants for the student I2C target.
// The FSM state enum is used by the top-level protocol engine.
package student_iic_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6
  } iic_tgt_state_e;

  localparam logic       IicAckBit      = 1'b0;
  localparam logic [3:0] IicBitsPerByte = 4'd8;

endpackage

// File: rtl/student_iic_sync_edge.sv
// Pad input synchroniser plus one registered copy for edge detection.
// level_o is the synchronised value; rise_o/fall_o are one-cycle pulses.
module student_iic_sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  // NOTE: synchroniser flops reset to 1 so a reset bus looks idle and no false START/STOP appears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = sync_q[SyncStages-1] & ~prev_q;
  assign fall_o  = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/student_iic_target.sv
// I2C target with fixed device address and a pointer-addressed byte register space.
// No clock stretching; SDA is only ever changed in the cycle after a synced SCL fall.
module student_iic_target
  import student_iic_target_pkg::*;
#(
  parameter logic [6:0] DevAddr    = 7'h1A,
  parameter int         PtrWidth   = 4,
  parameter int         SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe_o,
  output logic                wr_valid_o,
  output logic [PtrWidth-1:0] wr_addr_o,
  output logic [7:0]          wr_data_o,
  output logic [PtrWidth-1:0] rd_addr_o,
  input  logic [7:0]          rd_data_i,
  output logic                busy_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  student_iic_sync_edge #(.SyncStages(SyncStages)) u_scl_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (scl_i),
    .level_o(scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  student_iic_sync_edge #(.SyncStages(SyncStages)) u_sda_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sda_i),
    .level_o(sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl & sda_fall;
  assign stop_det  = scl & sda_rise;

  iic_tgt_state_e      state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic                ptr_byte_q, ptr_byte_d;
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [PtrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {shift_q[6:0], sda};
  assign last_bit = (bit_cnt_q == IicBitsPerByte - 4'd1);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ptr_byte_d = ptr_byte_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          shift_d   = '0;
          sda_oe_d  = 1'b0;
        end
        ST_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            if (rx_byte[7:1] == DevAddr) begin
              state_d    = ST_ADDR_ACK;
              busy_d     = 1'b1;
              rw_d       = rx_byte[0];
              ptr_byte_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        // First fall starts driving the ACK, second fall ends the ACK clock.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~IicAckBit;
          end else if (rw_q) begin
            state_d   = ST_RD_BYTE;
            shift_d   = rd_data_i;
            sda_oe_d  = ~rd_data_i[7];
            bit_cnt_d = '0;
          end else begin
            state_d   = ST_WR_BYTE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_WR_BYTE: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            state_d = ST_WR_ACK;
            if (ptr_byte_q) begin
              ptr_d      = rx_byte[PtrWidth-1:0];
              ptr_byte_d = 1'b0;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
              ptr_d      = ptr_q + PtrWidth'(1);
            end
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~IicAckBit;
          end else begin
            state_d   = ST_WR_BYTE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_RD_BYTE: if (scl_fall) begin
          if (last_bit) begin
            state_d  = ST_RD_ACK;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + PtrWidth'(1);
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // Any fall seen here follows an ACK: a NACK leaves on the preceding rise.
        ST_RD_ACK: begin
          if (scl_rise && (sda != IicAckBit)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d   = ST_RD_BYTE;
            shift_d   = rd_data_i;
            sda_oe_d  = ~rd_data_i[7];
            bit_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ptr_byte_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ptr_byte_q <= ptr_byte_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rd_addr_o  = ptr_q;
  assign busy_o     = busy_q;

endmodule
